// File: rtl/mxrv_pc_gen_if.sv
// Request/redirect bundle between the mxrv fetch-side control and the PC generator.
// The master drives hold/redirect/ready; the slave (PC generator) drives the fetch request.
interface mxrv_pc_gen_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  hold_flag_i;
    logic                  jump_flag_i;
    logic [ADDR_WIDTH-1:0] jump_addr_i;
    logic                  trap_flag_i;
    logic [ADDR_WIDTH-1:0] trap_addr_i;
    logic                  fetch_ready_i;
    logic                  fetch_valid_o;
    logic [ADDR_WIDTH-1:0] pc_o;
    logic                  pend_o;
    logic                  misalign_o;

    modport master (
        output hold_flag_i, jump_flag_i, jump_addr_i, trap_flag_i, trap_addr_i, fetch_ready_i,
        input  fetch_valid_o, pc_o, pend_o, misalign_o
    );

    modport slave (
        input  hold_flag_i, jump_flag_i, jump_addr_i, trap_flag_i, trap_addr_i, fetch_ready_i,
        output fetch_valid_o, pc_o, pend_o, misalign_o
    );
endinterface

// File: rtl/mxrv_pc_gen.sv
// mxrv fetch-stage PC generator: handshake-driven increment, trap-over-jump redirects,
// and a single pending slot that holds a redirect arriving while the pipeline is held.
module mxrv_pc_gen #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0,
    parameter int unsigned           STEP       = 4,
    parameter int unsigned           ALIGN_BITS = 2
) (
    input logic          clk,
    input logic          rst_n,
    mxrv_pc_gen_if.slave bus
);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~({ADDR_WIDTH{1'b1}} << ALIGN_BITS);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic                  pend_q, pend_d;
    logic                  pend_trap_q, pend_trap_d;
    logic                  misalign_q, misalign_d;
    logic                  started_q;

    logic [ADDR_WIDTH-1:0] sel_raw;
    logic [ADDR_WIDTH-1:0] sel_aligned;
    logic                  sel_misalign;
    logic                  new_wins;
    logic                  accept;

    assign sel_raw      = bus.trap_flag_i ? bus.trap_addr_i : bus.jump_addr_i;
    assign sel_aligned  = sel_raw & ~ALIGN_MASK;
    assign sel_misalign = |(sel_raw & ALIGN_MASK);
    // A new trap always wins; a new jump loses only to an already pending trap.
    assign new_wins     = bus.trap_flag_i | (bus.jump_flag_i & ~(pend_q & pend_trap_q));
    assign accept       = bus.fetch_valid_o & bus.fetch_ready_i;

    // NOTE: every next-state signal gets its hold value first, so no path through the
    // decision tree can leave one unassigned and infer a latch.
    always_comb begin
        pc_d        = pc_q;
        pend_d      = pend_q;
        pend_trap_d = pend_trap_q;
        pend_addr_d = pend_addr_q;
        misalign_d  = 1'b0;

        if (bus.hold_flag_i) begin
            if (new_wins) begin
                pend_d      = 1'b1;
                pend_trap_d = bus.trap_flag_i;
                pend_addr_d = sel_aligned;
                misalign_d  = sel_misalign;
            end
        end else if (new_wins) begin
            pc_d       = sel_aligned;
            pend_d     = 1'b0;
            misalign_d = sel_misalign;
        end else if (pend_q) begin
            // Covers both a plain release and a new jump beaten by a pending trap.
            pc_d   = pend_addr_q;
            pend_d = 1'b0;
        end else if (accept) begin
            pc_d = pc_q + ADDR_WIDTH'(STEP);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge value of its peers regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_ADDR;
            started_q   <= 1'b0;
            pend_q      <= 1'b0;
            pend_trap_q <= 1'b0;
            pend_addr_q <= '0;
            misalign_q  <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            started_q   <= 1'b1;
            pend_q      <= pend_d;
            pend_trap_q <= pend_trap_d;
            pend_addr_q <= pend_addr_d;
            misalign_q  <= misalign_d;
        end
    end

    assign bus.fetch_valid_o = started_q & ~bus.hold_flag_i;
    assign bus.pc_o          = pc_q;
    assign bus.pend_o        = pend_q;
    assign bus.misalign_o    = misalign_q;
endmodule

// File: doc/mxrv_pc_gen.md
Name: mxrv_pc_gen

Overview:
Parametrised next-generation PC generator for the mxrv core fetch stage. It drives the fetch address with a valid/ready handshake and advances the PC only when a fetch is accepted. It supports two prioritised redirect sources, trap over jump. A redirect that arrives during a hold is captured in a pending slot, not lost, and applied when the hold releases. Redirect targets are forced to instruction alignment, with a misalignment flag.

Parameters:
ADDR_WIDTH, 32, width of PC and redirect addresses
RESET_ADDR, 0, PC value loaded on reset
STEP, 4, byte increment per accepted fetch (2 for compressed-only builds)
ALIGN_BITS, 2, number of PC LSBs forced to zero on redirect (1 when STEP=2)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
hold_flag_i  in  1  pipeline hold; PC frozen, fetch request withdrawn
jump_flag_i  in  1  branch/jump redirect request, single-cycle pulse
jump_addr_i  in  ADDR_WIDTH  jump target
trap_flag_i  in  1  trap/exception redirect request, single-cycle pulse
trap_addr_i  in  ADDR_WIDTH  trap vector
fetch_ready_i  in  1  fetch unit accepts current pc_o
fetch_valid_o  out  1  pc_o is a valid fetch request
pc_o  out  ADDR_WIDTH  current fetch PC (registered)
pend_o  out  1  redirect pending (captured during hold)
misalign_o  out  1  one-cycle pulse: applied redirect target had nonzero low ALIGN_BITS

Behaviour:
- Reset (async, rst_n=0): pc=RESET_ADDR, started=0, pend=0, pend_addr=0, misalign=0. Outputs: pc_o=RESET_ADDR, fetch_valid_o=0, pend_o=0, misalign_o=0.
- started sets on the first clock edge after rst_n deasserts. fetch_valid_o = started & !hold_flag_i, combinational.
- Accepted fetch: fetch_valid_o & fetch_ready_i.
- Selected redirect (sel): trap_flag_i wins over jump_flag_i. If both are asserted, the jump is dropped.
- Aligned address: the selected address with its low ALIGN_BITS cleared. misalign_o is registered, set on the edge a redirect is applied or captured if the raw address had nonzero low bits; cleared otherwise.
- Per rising edge, highest priority first:
  1. hold_flag_i=1 and a redirect is requested: capture into the pending slot, pend<=1; pc unchanged.
     - A new trap always overwrites the pending slot.
     - A new jump overwrites only a pending jump, never a pending trap. A pending-type bit is kept for this.
  2. hold_flag_i=1, no redirect: pc and pend unchanged.
  3. hold_flag_i=0 and a redirect is requested this cycle: pc<=aligned target, pend<=0.
     - A new trap beats any pending entry.
     - A new jump beats a pending jump.
     - A pending trap beats a new jump; pc<=pend_addr.
  4. hold_flag_i=0, pend=1, no new redirect: pc<=pend_addr, pend<=0.
  5. Accepted fetch: pc<=pc+STEP, modulo 2^ADDR_WIDTH (wrap-around, no flag).
  6. Otherwise (fetch_ready_i=0 or !started): pc unchanged.
- A redirect overrides the increment. The fetch accepted in the same cycle is considered squashed by downstream logic.
- Latency: redirect at edge N drives pc_o = target after edge N, with fetch_valid_o high in that cycle if not held.
- Redirects before started=1 are applied normally, per rule 3.
- Reset mid-hold or with pend=1: all state returns to reset values and the pending redirect is discarded.
- pend_o = pend register.

Test Plan:
- Reset release, fetch_ready_i=1 for 4 cycles, RESET_ADDR=0 -> fetch_valid_o=0 in the first cycle, then pc_o 0,4,8,C across successive cycles.
- fetch_ready_i=0 for 3 cycles at pc=0x10 -> pc_o stays 0x10 and fetch_valid_o stays 1; ready returns -> 0x14.
- jump_flag_i=1 with addr 0x203 while ready=1 -> pc_o=0x200 next cycle, misalign_o pulses one cycle, then 0x204.
- hold_flag_i=1, jump pulse 0x400, then trap pulse 0x80, then jump 0x500, hold released -> pend_o=1 during hold, fetch_valid_o=0, pc unchanged; after release pc_o=0x80, pend_o=0.
- Same-cycle trap 0x100 and jump 0x300 with hold=0 -> pc_o=0x100. Separately, with ADDR_WIDTH=32 and pc=0xFFFFFFFC accepted -> pc_o=0x0.
- rst_n asserted asynchronously mid-cycle while pend=1 -> pc_o=RESET_ADDR and pend_o=0 immediately, without waiting for clk; after release the pending target is never applied.
